// File: rtl/dlf_gear_controller.sv
// Gear sequencer for the ADPLL third-order loop filter.
// Steps ACQ -> TRK1 -> TRK2 -> LOCKED on error windows, restarts on loss of lock.
module dlf_gear_controller #(
  parameter int inout_width = 8,
  parameter int cnt_width   = 8,
  parameter int LOCK_TH     = 4,
  parameter int UNLOCK_TH   = 32,
  parameter int LOCK_CNT    = 64,
  parameter int SETTLE      = 16,
  parameter int UNLOCK_CNT  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   err_valid,
  input  logic [inout_width-1:0] err_mag,
  output logic [1:0]             gear,
  output logic                   dlf_rstn,
  output logic                   dco_hold,
  output logic                   locked,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACQ    = 3'd2,
    TRK1   = 3'd3,
    TRK2   = 3'd4,
    LOCKED = 3'd5
  } state_t;

  localparam logic [inout_width-1:0] LTH =
    inout_width'(LOCK_TH);
  localparam logic [inout_width-1:0] UTH =
    inout_width'(UNLOCK_TH);
  localparam logic [cnt_width-1:0] LCNT_M1 =
    cnt_width'(LOCK_CNT - 1);
  localparam logic [cnt_width-1:0] UCNT_M1 =
    cnt_width'(UNLOCK_CNT - 1);
  localparam logic [cnt_width-1:0] SET =
    cnt_width'(SETTLE);
  localparam logic [cnt_width-1:0] CONE = cnt_width'(1);
  localparam logic [cnt_width-1:0] CMAX = '1;

  state_t state, state_n;
  logic [cnt_width-1:0] settle_cnt, lock_cnt, bad_cnt;
  logic [cnt_width-1:0] settle_n, lock_n, bad_n;
  logic [cnt_width-1:0] lock_inc, bad_inc;
  logic clr_cnt, clr_n;
  logic good, bad, run_n;

  always_comb begin
    good     = err_mag <= LTH;
    bad      = err_mag > UTH;
    lock_inc = (lock_cnt == CMAX) ? lock_cnt : lock_cnt + CONE;
    bad_inc  = (bad_cnt == CMAX) ? bad_cnt : bad_cnt + CONE;
    state_n  = state;
    settle_n = settle_cnt;
    lock_n   = lock_cnt;
    bad_n    = bad_cnt;
    clr_n    = clr_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          clr_n   = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt) begin
          state_n  = ACQ;
          settle_n = SET;
          lock_n   = '0;
          bad_n    = '0;
          clr_n    = 1'b0;
        end else begin
          clr_n = 1'b1;
        end
      end
      ACQ, TRK1, TRK2, LOCKED: begin
        if (err_valid) begin
          if (settle_cnt != '0) begin
            settle_n = settle_cnt - CONE;
          end else begin
            if (state != ACQ)
              bad_n = bad ? bad_inc : '0;
            // unlock outranks gear advance on the same sample
            if (state != ACQ && bad && bad_cnt >= UCNT_M1) begin
              state_n = CLEAR;
              clr_n   = 1'b0;
              lock_n  = '0;
              bad_n   = '0;
            end else if (state != LOCKED) begin
              if (!good) begin
                lock_n = '0;
              end else if (lock_cnt >= LCNT_M1) begin
                case (state)
                  ACQ:     state_n = TRK1;
                  TRK1:    state_n = TRK2;
                  default: state_n = LOCKED;
                endcase
                if (state != TRK2) begin
                  settle_n = SET;
                  lock_n   = '0;
                  bad_n    = '0;
                end
              end else begin
                lock_n = lock_inc;
              end
            end
          end
        end
      end
      default: begin
        state_n  = IDLE;
        settle_n = '0;
        lock_n   = '0;
        bad_n    = '0;
        clr_n    = 1'b0;
      end
    endcase
    if (stop) begin
      state_n  = IDLE;
      settle_n = '0;
      lock_n   = '0;
      bad_n    = '0;
      clr_n    = 1'b0;
    end
    run_n = state_n inside {ACQ, TRK1, TRK2, LOCKED};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      lock_cnt   <= '0;
      bad_cnt    <= '0;
      clr_cnt    <= 1'b0;
      gear       <= 2'd0;
      dlf_rstn   <= 1'b0;
      dco_hold   <= 1'b1;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      lock_cnt   <= lock_n;
      bad_cnt    <= bad_n;
      clr_cnt    <= clr_n;
      dlf_rstn   <= run_n;
      dco_hold   <= !run_n;
      locked     <= state_n == LOCKED;
      case (state_n)
        TRK1:        gear <= 2'd1;
        TRK2,LOCKED: gear <= 2'd2;
        default:     gear <= 2'd0;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dlf_gear_controller.sv
// Scoreboard bench for dlf_gear_controller.
// Segments of stimulus push expected state/outputs; each cycle pops and compares.
module tb_dlf_gear_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       err_valid = 1'b0;
  logic [7:0] err_mag = 8'd0;
  logic [1:0] gear;
  logic       dlf_rstn;
  logic       dco_hold;
  logic       locked;
  logic [2:0] state_o;

  dlf_gear_controller #(
    .inout_width(8),
    .cnt_width(8),
    .LOCK_TH(4),
    .UNLOCK_TH(32),
    .LOCK_CNT(64),
    .SETTLE(16),
    .UNLOCK_CNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .err_valid(err_valid),
    .err_mag(err_mag),
    .gear(gear),
    .dlf_rstn(dlf_rstn),
    .dco_hold(dco_hold),
    .locked(locked),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       r;
    logic       st;
    logic       sp;
    logic       v;
    logic [7:0] e;
    logic [2:0] s;
  } seg_t;

  seg_t       segs[$];
  logic [7:0] sb[$];
  int         checks = 0;
  int         failures = 0;

  // {gear, dlf_rstn, dco_hold, locked} for each state code
  function automatic logic [4:0] exp_out(logic [2:0] s);
    case (s)
      3'd0, 3'd1: return {2'd0, 1'b0, 1'b1, 1'b0};
      3'd2:       return {2'd0, 1'b1, 1'b0, 1'b0};
      3'd3:       return {2'd1, 1'b1, 1'b0, 1'b0};
      3'd4:       return {2'd2, 1'b1, 1'b0, 1'b0};
      3'd5:       return {2'd2, 1'b1, 1'b0, 1'b1};
      default:    return 5'b0;
    endcase
  endfunction

  task automatic add(input int n, input logic r, input logic st,
                     input logic sp, input logic v,
                     input logic [7:0] e, input logic [2:0] s);
    seg_t g;
    g.n = n; g.r = r; g.st = st; g.sp = sp;
    g.v = v; g.e = e; g.s = s;
    segs.push_back(g);
  endtask

  task automatic drive(input seg_t g);
    rst = g.r;
    start = g.st;
    stop = g.sp;
    err_valid = g.v;
    err_mag = g.e;
    sb.push_back({g.s, exp_out(g.s)});
  endtask

  task automatic test_reset();
    seg_t g;
    logic [7:0] got, exp;
    add(3, 1, 1, 0, 0, 8'd0, 3'd0);
    add(2, 0, 0, 0, 1, 8'd0, 3'd0);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL reset: got %h want %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_clean_acq();
    seg_t g;
    logic [7:0] got, exp;
    add(1, 0, 1, 0, 1, 8'd0, 3'd1);
    add(1, 0, 0, 0, 1, 8'd0, 3'd1);
    add(1, 0, 0, 0, 1, 8'd0, 3'd2);
    add(79, 0, 0, 0, 1, 8'd0, 3'd2);
    add(80, 0, 0, 0, 1, 8'd0, 3'd3);
    add(80, 0, 0, 0, 1, 8'd0, 3'd4);
    add(3, 0, 0, 0, 1, 8'd0, 3'd5);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL clean_acq: got %h want %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_unlock();
    seg_t g;
    logic [7:0] got, exp;
    add(3, 0, 0, 0, 1, 8'd40, 3'd5);
    add(1, 0, 0, 0, 1, 8'd0, 3'd5);
    add(3, 0, 0, 0, 1, 8'd40, 3'd5);
    add(1, 0, 0, 0, 1, 8'd40, 3'd1);
    add(1, 0, 0, 0, 0, 8'd0, 3'd1);
    add(1, 0, 0, 0, 0, 8'd0, 3'd2);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL unlock: got %h want %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_stop_override();
    seg_t g;
    logic [7:0] got, exp;
    add(79, 0, 0, 0, 1, 8'd0, 3'd2);
    add(80, 0, 0, 0, 1, 8'd0, 3'd3);
    add(5, 0, 0, 0, 1, 8'd0, 3'd4);
    add(1, 0, 1, 1, 1, 8'd0, 3'd0);
    add(2, 0, 0, 0, 1, 8'd0, 3'd0);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL stop_override: got %h want %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_window_break();
    seg_t g;
    logic [7:0] got, exp;
    add(1, 0, 1, 0, 1, 8'd200, 3'd1);
    add(1, 0, 0, 0, 1, 8'd200, 3'd1);
    add(1, 0, 0, 0, 1, 8'd200, 3'd2);
    add(79, 0, 0, 0, 1, 8'd0, 3'd2);
    add(1, 0, 0, 0, 1, 8'd5, 3'd2);
    add(63, 0, 0, 0, 1, 8'd0, 3'd2);
    add(1, 0, 0, 0, 1, 8'd0, 3'd3);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL window_break: got %h want %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_thresholds();
    seg_t g;
    logic [7:0] got, exp;
    add(16, 0, 0, 0, 1, 8'd100, 3'd3);
    add(4, 0, 0, 0, 1, 8'd32, 3'd3);
    add(2, 0, 0, 0, 1, 8'd33, 3'd3);
    add(2, 0, 0, 0, 0, 8'd33, 3'd3);
    add(1, 0, 0, 0, 1, 8'd33, 3'd3);
    add(1, 0, 0, 0, 1, 8'd33, 3'd1);
    add(1, 0, 0, 0, 0, 8'd0, 3'd1);
    add(1, 0, 0, 0, 0, 8'd0, 3'd2);
    add(79, 0, 0, 0, 1, 8'd4, 3'd2);
    add(1, 0, 0, 0, 1, 8'd4, 3'd3);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL thresholds: got %h want %h", got, exp);
        end
      end
    end
  endtask

  task automatic test_rst_override();
    seg_t g;
    logic [7:0] got, exp;
    add(79, 0, 0, 0, 1, 8'd0, 3'd3);
    add(80, 0, 0, 0, 1, 8'd0, 3'd4);
    add(2, 0, 0, 0, 1, 8'd0, 3'd5);
    add(1, 1, 0, 0, 1, 8'd0, 3'd0);
    add(1, 0, 1, 0, 1, 8'd0, 3'd1);
    add(1, 0, 0, 0, 1, 8'd0, 3'd1);
    add(1, 0, 0, 0, 1, 8'd0, 3'd2);
    add(79, 0, 0, 0, 1, 8'd0, 3'd2);
    add(80, 0, 0, 0, 1, 8'd0, 3'd3);
    add(80, 0, 0, 0, 1, 8'd0, 3'd4);
    add(2, 0, 0, 0, 1, 8'd0, 3'd5);
    while (segs.size() > 0) begin
      g = segs.pop_front();
      for (int i = 0; i < g.n; i++) begin
        drive(g);
        @(posedge clk); #1;
        got = {state_o, gear, dlf_rstn, dco_hold, locked};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rst_override: got %h want %h", got, exp);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_acq();
    test_unlock();
    test_stop_override();
    test_window_break();
    test_thresholds();
    test_rst_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
